sppm_rate_ctrl_mc: RTL and testbench

//   Multi-channel successor of the single-channel SPPM rate controller. Per channel: count SPPM

---
 rtl/sppm_rate_ctrl_mc.sv | 124 ++++++++++++
 tb/tb_sppm_rate_ctrl_mc.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/sppm_rate_ctrl_mc.sv
// Multi-channel SPPM rate controller: counts synchronized SPPM edges per window, steps a
// per-channel PWM duty word toward a shared target band, and reports rate, duty and lock.
module sppm_rate_ctrl_mc #(
    parameter int NCH       = 4,
    parameter int WIN_CYC   = 400000,
    parameter int CNT_W     = 17,
    parameter int W_W       = 9,
    parameter int W_MAX     = 400,
    parameter int W_INIT    = 0,
    parameter int STEP      = 1,
    parameter int PWM_PER   = 400,
    parameter int LOCK_WINS = 4
) (
    input  logic                 clk400M,
    input  logic                 rst,
    input  logic [NCH-1:0]       sppm,
    input  logic [NCH-1:0]       en,
    input  logic [CNT_W-1:0]     target,
    input  logic [CNT_W-1:0]     tol,
    output logic [NCH-1:0]       led,
    output logic [NCH*CNT_W-1:0] rate,
    output logic [NCH*W_W-1:0]   duty,
    output logic [NCH-1:0]       locked,
    output logic                 win_tick
);

    localparam int WC_W = (WIN_CYC > 1) ? $clog2(WIN_CYC) : 1;
    localparam int PC_W = (PWM_PER > 1) ? $clog2(PWM_PER) : 1;
    localparam int LK_W = $clog2(LOCK_WINS + 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic inc);
        return (inc && (c != '1)) ? c + CNT_W'(1) : c;
    endfunction

    function automatic logic [W_W-1:0] duty_up(input logic [W_W-1:0] d);
        logic [W_W:0] s;
        s = {1'b0, d} + (W_W+1)'(STEP);
        return (s > (W_W+1)'(W_MAX)) ? W_W'(W_MAX) : s[W_W-1:0];
    endfunction

    function automatic logic [W_W-1:0] duty_dn(input logic [W_W-1:0] d);
        return (d < W_W'(STEP)) ? '0 : d - W_W'(STEP);
    endfunction

    logic [NCH-1:0]   sync1_p0, sync2_p1, dly_p2, mono_p2;
    logic [WC_W-1:0]  wcnt_p0;
    logic [PC_W-1:0]  pcnt_p0;
    logic [CNT_W-1:0] cnt_p3   [NCH];
    logic [CNT_W-1:0] cnt_nxt  [NCH];
    logic [CNT_W-1:0] rate_q   [NCH];
    logic [W_W-1:0]   duty_q   [NCH];
    logic [LK_W-1:0]  lock_q   [NCH];
    logic [CNT_W:0]   band_hi, band_lo;
    logic             win_end;

    assign win_end = (wcnt_p0 == WC_W'(WIN_CYC - 1));

    // band is one bit wider than the count so target+tol cannot wrap
    always_comb begin
        band_hi = {1'b0, target} + {1'b0, tol};
        band_lo = (target >= tol) ? {1'b0, target - tol} : '0;
        for (int i = 0; i < NCH; i++) begin
            cnt_nxt[i] = sat_inc(cnt_p3[i], mono_p2[i]);
        end
    end

    always_ff @(posedge clk400M) begin
        if (rst) begin
            sync1_p0 <= '0;
            sync2_p1 <= '0;
            dly_p2   <= '0;
            mono_p2  <= '0;
            wcnt_p0  <= '0;
            pcnt_p0  <= '0;
            win_tick <= 1'b0;
            led      <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt_p3[i] <= '0;
                rate_q[i] <= '0;
                duty_q[i] <= W_W'(W_INIT);
                lock_q[i] <= '0;
            end
        end else begin
            // stage 0-2: synchronizer, delay and one-cycle rising-edge pulse
            sync1_p0 <= sppm;
            sync2_p1 <= sync1_p0;
            dly_p2   <= sync2_p1;
            mono_p2  <= sync2_p1 & ~dly_p2;

            win_tick <= win_end;
            wcnt_p0  <= win_end ? '0 : wcnt_p0 + WC_W'(1);
            pcnt_p0  <= (pcnt_p0 == PC_W'(PWM_PER - 1)) ? '0 : pcnt_p0 + PC_W'(1);

            // stage 3: window accumulation and end-of-window regulation
            for (int i = 0; i < NCH; i++) begin
                led[i] <= int'(pcnt_p0) < int'(duty_q[i]);
                if (win_end) begin
                    cnt_p3[i] <= '0;
                    rate_q[i] <= cnt_nxt[i];
                    if (!en[i]) begin
                        lock_q[i] <= '0;
                    end else if ({1'b0, cnt_nxt[i]} > band_hi) begin
                        duty_q[i] <= duty_dn(duty_q[i]);
                        lock_q[i] <= '0;
                    end else if ({1'b0, cnt_nxt[i]} < band_lo) begin
                        duty_q[i] <= duty_up(duty_q[i]);
                        lock_q[i] <= '0;
                    end else if (lock_q[i] != LK_W'(LOCK_WINS)) begin
                        lock_q[i] <= lock_q[i] + LK_W'(1);
                    end
                end else begin
                    cnt_p3[i] <= cnt_nxt[i];
                end
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_out
        assign rate[g*CNT_W +: CNT_W] = rate_q[g];
        assign duty[g*W_W +: W_W]     = duty_q[g];
        assign locked[g]              = (lock_q[g] == LK_W'(LOCK_WINS));
    end

endmodule

// File: tb/tb_sppm_rate_ctrl_mc.sv
// Randomized bench for sppm_rate_ctrl_mc: edge counts, band decisions, duty, lock and PWM
// are predicted from sampled input waveforms with plain arithmetic per window.
module tb_sppm_rate_ctrl_mc;

    localparam int NCH   = 4;
    localparam int WIN   = 256;
    localparam int CW    = 7;
    localparam int WW    = 9;
    localparam int WMAX  = 16;
    localparam int WINIT = 1;
    localparam int STEP  = 2;
    localparam int PER   = 16;
    localparam int LOCK  = 4;
    localparam int MAXC  = (1 << CW) - 1;
    localparam int MAXW  = 64;

    logic              clk400M = 1'b0;
    logic              rst;
    logic [NCH-1:0]    sppm, en;
    logic [CW-1:0]     target, tol;
    logic [NCH-1:0]    led;
    logic [NCH*CW-1:0] rate;
    logic [NCH*WW-1:0] duty;
    logic [NCH-1:0]    locked;
    logic              win_tick;

    sppm_rate_ctrl_mc #(
        .NCH(NCH), .WIN_CYC(WIN), .CNT_W(CW), .W_W(WW), .W_MAX(WMAX), .W_INIT(WINIT),
        .STEP(STEP), .PWM_PER(PER), .LOCK_WINS(LOCK)
    ) dut (
        .clk400M(clk400M), .rst(rst), .sppm(sppm), .en(en), .target(target), .tol(tol),
        .led(led), .rate(rate), .duty(duty), .locked(locked), .win_tick(win_tick)
    );

    always #2 clk400M = ~clk400M;

    int errors = 0;
    int checks = 0;

    // reference state: edges per window, duty, lock run length, PWM high count
    int mcnt  [NCH][MAXW];
    int mduty [NCH];
    int mlock [NCH];
    int prev  [NCH];
    int np    [NCH];
    bit held  [NCH];
    int highs [NCH];
    int k;
    int pw;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, k);
        end
    endtask

    function automatic int mn(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int clampn(input int v);
        return (v < 0) ? 0 : ((v > WIN/2) ? WIN/2 : v);
    endfunction

    task automatic model_reset();
        k = 0;
        for (int c = 0; c < NCH; c++) begin
            for (int w = 0; w < MAXW; w++) mcnt[c][w] = 0;
            mduty[c] = WINIT;
            mlock[c] = 0;
            prev[c]  = 0;
            highs[c] = 0;
        end
    endtask

    task automatic choose_plan();
        int hi, lo, r;
        for (int c = 0; c < NCH; c++) held[c] = 1'b0;
        if (pw < 12) begin
            target = CW'(80);
            tol    = CW'(4);
            en     = {1'($urandom_range(0, 1)), 3'b111};
            np[0]  = $urandom_range(40, 70);
            np[1]  = $urandom_range(90, 128);
            np[2]  = (pw < 6) ? ((pw % 2 == 1) ? 84 : 76) : ((pw == 6) ? 85 : 80);
            np[3]  = $urandom_range(0, 128);
        end else if (pw < 17) begin
            en[2] = (pw >= 15);
            np[0] = 50;
            np[1] = 100;
            np[2] = 60;
            np[3] = $urandom_range(0, 128);
        end else begin
            if (pw % 5 == 0) begin
                target = CW'($urandom_range(0, 127));
                tol    = CW'($urandom_range(0, 40));
            end
            en = NCH'($urandom | $urandom);
            hi = int'(target) + int'(tol);
            lo = (target >= tol) ? int'(target) - int'(tol) : 0;
            for (int c = 0; c < NCH; c++) begin
                r = $urandom_range(0, 9);
                if (r == 0) begin
                    held[c] = 1'b1;
                    np[c]   = 0;
                end else if (r <= 2) np[c] = clampn(hi + r - 1);
                else if (r <= 4)     np[c] = clampn(lo - r + 3);
                else if (r <= 6)     np[c] = $urandom_range(0, 128);
                else                 np[c] = clampn(lo - 3 + $urandom_range(0, hi - lo + 6));
            end
        end
        pw++;
    endtask

    // drive sppm for edge k; pulses sit on odd offsets ending at the last cycle
    // whose edge is counted in the window, so the last pulse lands on window end
    task automatic drive_inputs();
        int wn, loc;
        bit sp;
        wn  = (k + 3) / WIN;
        loc = (k + 3) % WIN;
        if (loc == 0 || k == 0) choose_plan();
        for (int c = 0; c < NCH; c++) begin
            sp = held[c] || ((loc % 2 == 1) && (loc >= WIN + 1 - 2 * np[c]));
            sppm[c] = sp;
            if (sp && prev[c] == 0 && wn < MAXW) mcnt[c][wn]++;
            prev[c] = sp;
        end
    endtask

    task automatic check_edge();
        int w, hi, lo, cv;
        check_val("win_tick", 32'(win_tick), 32'(k % WIN == WIN - 1));
        for (int c = 0; c < NCH; c++) highs[c] += int'(led[c]);
        if (k % PER == PER - 1) begin
            for (int c = 0; c < NCH; c++) begin
                check_val($sformatf("led_high_cycles[%0d]", c), 32'(highs[c]), 32'(mn(mduty[c], PER)));
                highs[c] = 0;
            end
        end
        if (k % WIN == WIN - 1) begin
            w  = k / WIN;
            hi = int'(target) + int'(tol);
            lo = (target >= tol) ? int'(target) - int'(tol) : 0;
            for (int c = 0; c < NCH; c++) begin
                cv = (w < MAXW) ? mn(mcnt[c][w], MAXC) : 0;
                if (en[c]) begin
                    if (cv > hi) begin
                        mduty[c] = (mduty[c] < STEP) ? 0 : mduty[c] - STEP;
                        mlock[c] = 0;
                    end else if (cv < lo) begin
                        mduty[c] = mn(mduty[c] + STEP, WMAX);
                        mlock[c] = 0;
                    end else begin
                        mlock[c] = mn(mlock[c] + 1, LOCK);
                    end
                end else begin
                    mlock[c] = 0;
                end
                check_val($sformatf("rate[%0d]", c), 32'(rate[c*CW +: CW]), 32'(cv));
                check_val($sformatf("duty[%0d]", c), 32'(duty[c*WW +: WW]), 32'(mduty[c]));
                check_val($sformatf("locked[%0d]", c), 32'(locked[c]), 32'(mlock[c] == LOCK));
            end
        end
    endtask

    task automatic cycle();
        drive_inputs();
        @(posedge clk400M);
        @(negedge clk400M);
        check_edge();
        k++;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        sppm = NCH'($urandom);
        @(posedge clk400M);
        @(negedge clk400M);
        check_val("rst_win_tick", 32'(win_tick), 32'(0));
        check_val("rst_led", 32'(led), 32'(0));
        check_val("rst_locked", 32'(locked), 32'(0));
        for (int c = 0; c < NCH; c++) begin
            check_val($sformatf("rst_rate[%0d]", c), 32'(rate[c*CW +: CW]), 32'(0));
            check_val($sformatf("rst_duty[%0d]", c), 32'(duty[c*WW +: WW]), 32'(WINIT));
        end
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        rst    = 1'b1;
        sppm   = '0;
        en     = '1;
        target = CW'(80);
        tol    = CW'(4);
        pw     = 0;
        model_reset();
        @(posedge clk400M);
        do_reset();
        while (!(pw >= 42 && (k % WIN) == 100)) cycle();
        do_reset();
        do cycle(); while (!(pw >= 80 && (k % WIN) == 0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
